musb_scoreboard_hazard_unit: RTL

- Parametrised, sequential successor to the combinational hazard/forwarding logic.
- Keeps a per-GPR scoreboard of in-flight writes, each with its own result latency. The pipeline can therefore host multi-cycle units (mult/div, long loads) without hard-coded EX/MEM/WB compares.
- Sits beside the ID stage. Drives ID stall and per-read-port forwarding selects, and counts stall cycles for performance monitoring.

---
 rtl/musb_scoreboard_hazard_unit_pkg.sv | 19 +
 rtl/musb_scoreboard_entry.sv | 54 +++++
 rtl/musb_scoreboard_hazard_unit.sv | 97 +++++++++
 3 files changed

// File: rtl/musb_scoreboard_hazard_unit_pkg.sv
// Shared encodings and default result latencies for the GPR scoreboard hazard unit.
package musb_scoreboard_hazard_unit_pkg;

  localparam int unsigned GPR_AW  = 5;
  localparam int unsigned NUM_GPR = 32;
  localparam int unsigned FWD_W   = 2;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_MEM     = 2'b01,
    FWD_WB      = 2'b10
  } fwd_sel_e;

  // A load uses LOAD_LAT together with ld=1: its data only exists one stage later, at WB.
  localparam int unsigned ALU_LAT    = 1;
  localparam int unsigned LOAD_LAT   = 1;
  localparam int unsigned MULDIV_LAT = 4;

endpackage

// File: rtl/musb_scoreboard_entry.sv
// State for one tracked GPR: an in-flight write with its age, result latency and load flag.
module musb_scoreboard_entry
  import musb_scoreboard_hazard_unit_pkg::*;
#(
  parameter int unsigned LAT_W     = 4,
  parameter int unsigned FLUSH_AGE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_lat,
  input  logic             load_ld,
  input  logic             pipe_stall,
  input  logic             flush,
  output logic             valid,
  output logic [LAT_W-1:0] age,
  output logic [LAT_W-1:0] lat,
  output logic             ld
);

  localparam logic [LAT_W-1:0] ONE       = LAT_W'(1);
  localparam logic [LAT_W-1:0] FLUSH_LIM = LAT_W'(FLUSH_AGE);

  logic retire_c;

  // At age lat+1 the value is written to the regfile on this edge.
  assign retire_c = (age == lat + ONE);

  // A new write always wins over the old entry, even one retiring on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      age   <= '0;
      lat   <= '0;
      ld    <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      age   <= '0;
      lat   <= load_lat;
      ld    <= load_ld;
    end else if (valid) begin
      if (flush && (age < FLUSH_LIM)) begin
        valid <= 1'b0;
      end else if (!pipe_stall) begin
        if (retire_c) begin
          valid <= 1'b0;
        end else begin
          age <= age + ONE;
        end
      end
    end
  end

endmodule

// File: rtl/musb_scoreboard_hazard_unit.sv
// ID-stage hazard unit: per-GPR write scoreboard driving ID stall, forwarding selects and a stall counter.
module musb_scoreboard_hazard_unit
  import musb_scoreboard_hazard_unit_pkg::*;
#(
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned LAT_W        = 4,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned FLUSH_AGE    = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [GPR_AW*NUM_RD_PORTS-1:0] id_rs,
  input  logic [NUM_RD_PORTS-1:0]        id_rs_used,
  input  logic                           id_issue,
  input  logic                           id_gpr_we,
  input  logic [GPR_AW-1:0]              id_gpr_wa,
  input  logic [LAT_W-1:0]               id_lat,
  input  logic                           id_mem_to_gpr,
  input  logic                           pipe_stall,
  input  logic                           flush,
  output logic                           id_stall,
  output logic [FWD_W*NUM_RD_PORTS-1:0]  fwd_sel,
  output logic [CNT_W-1:0]               stall_cycles
);

  localparam logic [LAT_W-1:0] ONE = LAT_W'(1);

  logic [NUM_GPR-1:0]            valid_v;
  logic [NUM_GPR-1:0]            ld_v;
  logic [NUM_GPR-1:0][LAT_W-1:0] age_a;
  logic [NUM_GPR-1:0][LAT_W-1:0] lat_a;
  logic [GPR_AW-1:0]             rs_c;
  logic                          raw_c;
  logic                          waw_c;
  logic                          issue_ok_c;

  // r0 is hardwired as an empty slot so reads and writes of it never hazard.
  assign valid_v[0] = 1'b0;
  assign ld_v[0]    = 1'b0;
  assign age_a[0]   = '0;
  assign lat_a[0]   = '0;

  for (genvar g = 1; g < NUM_GPR; g++) begin : g_entry
    musb_scoreboard_entry #(
      .LAT_W     (LAT_W),
      .FLUSH_AGE (FLUSH_AGE)
    ) u_entry (
      .clk        (clk),
      .rst        (rst),
      .load       (issue_ok_c & ~flush & id_gpr_we & (id_gpr_wa == GPR_AW'(g))),
      .load_lat   (id_lat),
      .load_ld    (id_mem_to_gpr),
      .pipe_stall (pipe_stall),
      .flush      (flush),
      .valid      (valid_v[g]),
      .age        (age_a[g]),
      .lat        (lat_a[g]),
      .ld         (ld_v[g])
    );
  end

  // Per read port: RAW readiness and where the operand currently lives.
  always_comb begin
    raw_c   = 1'b0;
    fwd_sel = '0;
    rs_c    = '0;
    for (int unsigned i = 0; i < NUM_RD_PORTS; i++) begin
      rs_c = id_rs[GPR_AW*i +: GPR_AW];
      if (id_rs_used[i] && valid_v[rs_c]) begin
        if (age_a[rs_c] < lat_a[rs_c] + LAT_W'(ld_v[rs_c])) begin
          raw_c = 1'b1;
        end
        if ((age_a[rs_c] == lat_a[rs_c]) && !ld_v[rs_c]) begin
          fwd_sel[FWD_W*i +: FWD_W] = FWD_MEM;
        end else if (age_a[rs_c] == lat_a[rs_c] + ONE) begin
          fwd_sel[FWD_W*i +: FWD_W] = FWD_WB;
        end
      end
    end
  end

  // An older write with more cycles remaining would land after this one.
  assign waw_c = id_gpr_we && valid_v[id_gpr_wa] &&
                 ((lat_a[id_gpr_wa] + ONE - age_a[id_gpr_wa]) > id_lat);

  assign id_stall   = id_issue & (raw_c | waw_c);
  assign issue_ok_c = id_issue & ~id_stall & ~pipe_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (id_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
